// File: rtl/prog_ctr_if.sv
// Fetch-stage bus between the decode/control stage (master) and the program counter (slave).
// Carries run control, jump/branch/call/return requests and the registered fetch address.
interface prog_ctr_if #(
  parameter int unsigned D  = 12,
  parameter int unsigned OW = 8
);
  logic          start;
  logic          halt;
  logic          stall;
  logic          jump_en;
  logic [D-1:0]  jump_target;
  logic          branch_en;
  logic          branch_taken;
  logic [OW-1:0] branch_offset;
  logic          call_en;
  logic          ret_en;
  logic [D-1:0]  prog_ctr_out;
  logic          running;
  logic          done;
  logic          stack_err;

  modport master (
    output start, halt, stall, jump_en, jump_target, branch_en, branch_taken,
           branch_offset, call_en, ret_en,
    input  prog_ctr_out, running, done, stack_err
  );

  modport slave (
    input  start, halt, stall, jump_en, jump_target, branch_en, branch_taken,
           branch_offset, call_en, ret_en,
    output prog_ctr_out, running, done, stack_err
  );
endinterface

// File: rtl/prog_ctr.sv
// Program counter: IDLE/RUN/DONE sequencing, absolute jumps and PC-relative branches.
// Define PC_RET_STACK_EN to build the call/return stack; otherwise call_en/ret_en are ignored.
module prog_ctr #(
  parameter int unsigned D          = 12,
  parameter int unsigned OW         = 8,
  parameter int unsigned START_ADDR = 0,
  parameter int unsigned RS_DEPTH   = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  prog_ctr_if.slave    bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  state_t       state_q, state_d;
  logic [D-1:0] pc_q, pc_d;
  logic         running_q, running_d;
  logic         done_q, done_d;
  logic [D-1:0] pc_inc;
  logic [D-1:0] pc_br;

  // Both sums wrap modulo 2**D; the offset is sign-extended to D bits.
  assign pc_inc = pc_q + D'(1);
  assign pc_br  = pc_q + D'($signed(bus.branch_offset));

`ifdef PC_RET_STACK_EN
  localparam int unsigned SPW = $clog2(RS_DEPTH + 1);
  localparam int unsigned IW  = (RS_DEPTH > 1) ? $clog2(RS_DEPTH) : 1;

  logic [D-1:0]   stk_q [RS_DEPTH];
  logic [D-1:0]   stk_d [RS_DEPTH];
  logic [SPW-1:0] sp_q, sp_d;
  logic           err_q, err_d;
`else
  localparam int unsigned UNUSED_RS_DEPTH = RS_DEPTH;
  logic unused_stack_c;
  assign unused_stack_c = bus.call_en | bus.ret_en;
`endif

  // Next-state and next-PC selection.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
`ifdef PC_RET_STACK_EN
    stk_d   = stk_q;
    sp_d    = sp_q;
    err_d   = err_q;
`endif
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          state_d = ST_RUN;
          pc_d    = D'(START_ADDR);
`ifdef PC_RET_STACK_EN
          sp_d    = '0;
`endif
        end
      end
      ST_RUN: begin
        if (bus.start) begin
          pc_d    = D'(START_ADDR);
`ifdef PC_RET_STACK_EN
          sp_d    = '0;
`endif
        end else if (bus.halt) begin
          state_d = ST_DONE;
        end else if (!bus.stall) begin
`ifdef PC_RET_STACK_EN
          if (bus.ret_en) begin
            if (sp_q == '0) begin
              pc_d  = pc_inc;
              err_d = 1'b1;
            end else begin
              pc_d = stk_q[IW'(sp_q - SPW'(1))];
              sp_d = sp_q - SPW'(1);
            end
          end else if (bus.call_en) begin
            pc_d = bus.jump_target;
            if (sp_q == SPW'(RS_DEPTH)) begin
              err_d = 1'b1;
            end else begin
              stk_d[IW'(sp_q)] = pc_inc;
              sp_d             = sp_q + SPW'(1);
            end
          end else
`endif
          if (bus.jump_en) begin
            pc_d = bus.jump_target;
          end else if (bus.branch_en && bus.branch_taken) begin
            pc_d = pc_br;
          end else begin
            pc_d = pc_inc;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    running_d = (state_d == ST_RUN);
    done_d    = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pc_q      <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
`ifdef PC_RET_STACK_EN
      sp_q      <= '0;
      err_q     <= 1'b0;
      for (int i = 0; i < int'(RS_DEPTH); i++) stk_q[i] <= '0;
`endif
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      running_q <= running_d;
      done_q    <= done_d;
`ifdef PC_RET_STACK_EN
      sp_q      <= sp_d;
      err_q     <= err_d;
      for (int i = 0; i < int'(RS_DEPTH); i++) stk_q[i] <= stk_d[i];
`endif
    end
  end

  assign bus.prog_ctr_out = pc_q;
  assign bus.running      = running_q;
  assign bus.done         = done_q;
`ifdef PC_RET_STACK_EN
  assign bus.stack_err    = err_q;
`else
  assign bus.stack_err    = 1'b0;
`endif

endmodule

// File: tb/tb_prog_ctr.sv
// Testbench for prog_ctr: vector table, hand-written corner sequences, and randomized
// stimulus against a queue-based reference model. Works with or without PC_RET_STACK_EN.
module tb_prog_ctr;

  localparam int unsigned RSD = 2;
`ifdef PC_RET_STACK_EN
  localparam bit MAC = 1'b1;
`else
  localparam bit MAC = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  prog_ctr_if #(.D(12), .OW(8)) bus ();
  prog_ctr_if #(.D(4),  .OW(4)) bus4 ();

  prog_ctr #(.D(12), .OW(8), .START_ADDR(0), .RS_DEPTH(RSD)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave));
  prog_ctr #(.D(4), .OW(4), .START_ADDR(0), .RS_DEPTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(bus4.slave));

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    bus.start = 0; bus.halt = 0; bus.stall = 0; bus.jump_en = 0; bus.jump_target = '0;
    bus.branch_en = 0; bus.branch_taken = 0; bus.branch_offset = '0;
    bus.call_en = 0; bus.ret_en = 0;
    bus4.start = 0; bus4.halt = 0; bus4.stall = 0; bus4.jump_en = 0; bus4.jump_target = '0;
    bus4.branch_en = 0; bus4.branch_taken = 0; bus4.branch_offset = '0;
    bus4.call_en = 0; bus4.ret_en = 0;
  endtask

  typedef struct {
    logic st, hl, sl, jp;
    logic [11:0] jt;
    logic br, tk;
    logic [7:0] off;
    int e_pc;
    logic e_run, e_done;
  } vec_t;

  function automatic vec_t mk(logic st, logic hl, logic sl, logic jp, int jt, logic br,
                              logic tk, int off, int e_pc, logic e_run, logic e_done);
    vec_t v;
    v.st = st; v.hl = hl; v.sl = sl; v.jp = jp; v.jt = 12'(jt);
    v.br = br; v.tk = tk; v.off = 8'(off); v.e_pc = e_pc; v.e_run = e_run; v.e_done = e_done;
    return v;
  endfunction

  // Reference model: state as plain ints, return stack as a queue.
  int m_pc, m_state, m_err;   // m_state: 0 idle, 1 run, 2 done
  int m_stk[$];

  task automatic model_reset();
    m_pc = 0; m_state = 0; m_err = 0; m_stk.delete();
  endtask

  task automatic model_step();
    int off;
    int inc;
    inc = (m_pc + 1) % 4096;
    off = int'(bus.branch_offset);
    if (off >= 128) off -= 256;
    if (m_state != 1) begin
      if (bus.start) begin m_pc = 0; m_state = 1; m_stk.delete(); end
    end else if (bus.start) begin
      m_pc = 0; m_stk.delete();
    end else if (bus.halt) begin
      m_state = 2;
    end else if (bus.stall) begin
      m_pc = m_pc;
    end else if (MAC && bus.ret_en) begin
      if (m_stk.size() == 0) begin m_pc = inc; m_err = 1; end
      else m_pc = m_stk.pop_back();
    end else if (MAC && bus.call_en) begin
      if (m_stk.size() == int'(RSD)) m_err = 1;
      else m_stk.push_back(inc);
      m_pc = int'(bus.jump_target);
    end else if (bus.jump_en) begin
      m_pc = int'(bus.jump_target);
    end else if (bus.branch_en && bus.branch_taken) begin
      m_pc = ((m_pc + off) % 4096 + 4096) % 4096;
    end else begin
      m_pc = inc;
    end
  endtask

  vec_t tbl[$];
  int t6_pc[7];
  int t6_err[7];

  initial begin
    clr();
    rst_n = 0;
    #12;
    chk("reset_pc", int'(bus.prog_ctr_out), 0);
    chk("reset_running", int'(bus.running), 0);
    chk("reset_done", int'(bus.done), 0);
    chk("reset_stack_err", int'(bus.stack_err), 0);
    @(negedge clk) rst_n = 1;

    //          st hl sl jp jt   br tk off   pc  run done
    tbl.push_back(mk(0, 0, 0, 0, 0,    0, 0, 0,    0,    0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 9,    0, 0, 0,    0,    0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0,    0, 0, 0,    0,    1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0,    0, 0, 0,    1,    1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0,    0, 0, 0,    2,    1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0,    0, 0, 0,    3,    1, 0));
    tbl.push_back(mk(0, 0, 0, 1, 5,    0, 0, 0,    5,    1, 0));
    tbl.push_back(mk(0, 0, 1, 1, 9,    0, 0, 0,    5,    1, 0));
    tbl.push_back(mk(0, 0, 0, 1, 9,    1, 1, 2,    9,    1, 0));
    tbl.push_back(mk(0, 0, 0, 1, 10,   0, 0, 0,    10,   1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0,    1, 0, 5,    11,   1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0,    1, 1, 127,  138,  1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0,    1, 1, 0,    138,  1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0,    1, 1, 128,  10,   1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0,    1, 1, 253,  7,    1, 0));
    tbl.push_back(mk(0, 1, 0, 1, 9,    0, 0, 0,    7,    0, 1));
    tbl.push_back(mk(0, 0, 1, 1, 9,    0, 0, 0,    7,    0, 1));
    tbl.push_back(mk(0, 0, 0, 1, 4095, 0, 0, 0,    7,    0, 1));
    tbl.push_back(mk(1, 1, 0, 0, 0,    0, 0, 0,    0,    1, 0));
    tbl.push_back(mk(0, 0, 0, 1, 4095, 0, 0, 0,    4095, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0,    0, 0, 0,    0,    1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0,    1, 1, 255,  4095, 1, 0));
    tbl.push_back(mk(1, 1, 0, 1, 100,  0, 0, 0,    0,    1, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0,    0, 0, 0,    0,    0, 1));

    @(posedge clk); #1;
    foreach (tbl[i]) begin
      bus.start = tbl[i].st; bus.halt = tbl[i].hl; bus.stall = tbl[i].sl;
      bus.jump_en = tbl[i].jp; bus.jump_target = tbl[i].jt;
      bus.branch_en = tbl[i].br; bus.branch_taken = tbl[i].tk; bus.branch_offset = tbl[i].off;
      step();
      chk($sformatf("vec%0d_pc", i), int'(bus.prog_ctr_out), tbl[i].e_pc);
      chk($sformatf("vec%0d_running", i), int'(bus.running), int'(tbl[i].e_run));
      chk($sformatf("vec%0d_done", i), int'(bus.done), int'(tbl[i].e_done));
    end
    clr();

    // Narrow instance: wrap 15 -> 0 and negative branch underflow.
    bus4.start = 1; step(); bus4.start = 0;
    chk("w4_start", int'(bus4.prog_ctr_out), 0);
    bus4.jump_en = 1; bus4.jump_target = 4'd15; step(); bus4.jump_en = 0;
    chk("w4_jump15", int'(bus4.prog_ctr_out), 15);
    step(); chk("w4_wrap", int'(bus4.prog_ctr_out), 0);
    step(); chk("w4_pc1", int'(bus4.prog_ctr_out), 1);
    bus4.branch_en = 1; bus4.branch_taken = 1; bus4.branch_offset = 4'hD; step();
    chk("w4_br_neg3", int'(bus4.prog_ctr_out), 14);
    clr();

    // Asynchronous reset in the middle of a run.
    bus.start = 1; step(); bus.start = 0;
    for (int i = 0; i < 7; i++) step();
    chk("t5_pc7", int'(bus.prog_ctr_out), 7);
    #3 rst_n = 0;
    #1;
    chk("t5_async_pc", int'(bus.prog_ctr_out), 0);
    chk("t5_async_running", int'(bus.running), 0);
    step();
    chk("t5_held_pc", int'(bus.prog_ctr_out), 0);
    @(negedge clk) rst_n = 1;
    step();
    chk("t5_idle_pc", int'(bus.prog_ctr_out), 0);
    chk("t5_idle_running", int'(bus.running), 0);
    bus.start = 1; step(); bus.start = 0;
    chk("t5_restart_running", int'(bus.running), 1);
    step();
    chk("t5_restart_pc", int'(bus.prog_ctr_out), 1);

    // Call/return sequence with a 2-deep stack.
`ifdef PC_RET_STACK_EN
    t6_pc  = '{3, 20, 50, 70, 21, 4, 5};
    t6_err = '{0, 0, 0, 1, 1, 1, 1};
`else
    t6_pc  = '{3, 4, 5, 6, 7, 8, 9};
    t6_err = '{0, 0, 0, 0, 0, 0, 0};
`endif
    for (int i = 0; i < 7; i++) begin
      clr();
      case (i)
        0: begin bus.jump_en = 1; bus.jump_target = 12'd3; end
        1: begin bus.call_en = 1; bus.jump_target = 12'd20; end
        2: begin bus.call_en = 1; bus.jump_target = 12'd50; end
        3: begin bus.call_en = 1; bus.jump_target = 12'd70; end
        default: bus.ret_en = 1;
      endcase
      step();
      chk($sformatf("t6_%0d_pc", i), int'(bus.prog_ctr_out), t6_pc[i]);
      chk($sformatf("t6_%0d_err", i), int'(bus.stack_err), t6_err[i]);
    end
    clr();

    // Randomized run against the reference model.
    rst_n = 0; #2; rst_n = 1;
    model_reset();
    for (int c = 0; c < 600; c++) begin
      bus.start = ($urandom % 24) == 0;
      bus.halt = ($urandom % 16) == 0;
      bus.stall = ($urandom % 6) == 0;
      bus.ret_en = ($urandom % 7) == 0;
      bus.call_en = ($urandom % 7) == 0;
      bus.jump_en = ($urandom % 5) == 0;
      bus.jump_target = 12'($urandom);
      bus.branch_en = ($urandom % 3) == 0;
      bus.branch_taken = 1'($urandom);
      bus.branch_offset = 8'($urandom);
      model_step();
      step();
      chk("rnd_pc", int'(bus.prog_ctr_out), m_pc);
      chk("rnd_running", int'(bus.running), int'(m_state == 1));
      chk("rnd_done", int'(bus.done), int'(m_state == 2));
      chk("rnd_stack_err", int'(bus.stack_err), m_err);
    end
    clr();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
